hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 22 ++
 rtl/hazard_cmp.sv | 22 ++
 rtl/hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_hazard_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions: hazard controller state encoding, memory
// timeout default and PC source select encodings.
package hazard_ctrl_pkg;

  localparam int MEM_TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_TIMEOUT = 2'd2
  } hz_state_t;

  typedef enum logic [1:0] {
    PCSRC_SEQ    = 2'd0,
    PCSRC_BRANCH = 2'd1,
    PCSRC_JUMP   = 2'd2,
    PCSRC_JR     = 2'd3
  } pcsrc_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_cmp.sv
// Load-use detector: the load in EX writes a register the ID instruction reads.
module hazard_cmp
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] ID_Rs,
  input  logic [4:0] ID_Rt,
  input  logic       ID_UseRs,
  input  logic       ID_UseRt,
  input  logic       EX_MemRd,
  input  logic [4:0] EX_Rt,
  output logic       load_use
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit   = ID_UseRs & (ID_Rs == EX_Rt);
  assign rt_hit   = ID_UseRt & (ID_Rt == EX_Rt);
  // $zero is never really written, so a load targeting it cannot create a hazard
  assign load_use = EX_MemRd & (EX_Rt != REG_ZERO) & (rs_hit | rt_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch/jump flushes, memory
// wait stalls with timeout, and a saturating stall-cycle counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_UseRs,
  input  logic        ID_UseRt,
  input  logic        EX_MemRd,
  input  logic [4:0]  EX_Rt,
  input  logic        EX_BranchTaken,
  input  logic        ID_Jump,
  input  logic        Mem_Req,
  input  logic        Mem_Ready,
  output logic        PC_stall,
  output logic        IFID_stall,
  output logic        IFID_clear,
  output logic        IDEX_stall,
  output logic        IDEX_clear,
  output logic        EXMEM_stall,
  output logic [15:0] Stall_Count,
  output logic        Mem_Timeout
);

  localparam int CW = $clog2(MEM_TIMEOUT + 2);

  hz_state_t     state;
  hz_state_t     next_state;
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] wait_next;
  logic          load_use;
  logic          mem_busy;

  hazard_cmp u_cmp (
    .ID_Rs    (ID_Rs),
    .ID_Rt    (ID_Rt),
    .ID_UseRs (ID_UseRs),
    .ID_UseRt (ID_UseRt),
    .EX_MemRd (EX_MemRd),
    .EX_Rt    (EX_Rt),
    .load_use (load_use)
  );

  // A dropped request while waiting counts as completion
  assign mem_busy = Mem_Req & ~Mem_Ready;

  // Control outputs (active low) and next-state / wait-counter decode
  always_comb begin
    PC_stall    = 1'b1;
    IFID_stall  = 1'b1;
    IFID_clear  = 1'b1;
    IDEX_stall  = 1'b1;
    IDEX_clear  = 1'b1;
    EXMEM_stall = 1'b1;
    next_state  = state;
    wait_next   = wait_cnt;
    if (reset) begin
      next_state = ST_RUN;
      wait_next  = '0;
    end else begin
      if ((state == ST_TIMEOUT) || mem_busy) begin
        PC_stall    = 1'b0;
        IFID_stall  = 1'b0;
        IDEX_stall  = 1'b0;
        EXMEM_stall = 1'b0;
      end else if (EX_BranchTaken) begin
        IFID_clear = 1'b0;
        IDEX_clear = 1'b0;
      end else if (load_use) begin
        PC_stall   = 1'b0;
        IFID_stall = 1'b0;
        IDEX_clear = 1'b0;
      end else if (ID_Jump) begin
        IFID_clear = 1'b0;
      end else begin
        PC_stall = 1'b1;
      end

      case (state)
        ST_RUN: begin
          if (mem_busy) begin
            next_state = ST_MEMWAIT;
            wait_next  = CW'(1);
          end else begin
            next_state = ST_RUN;
          end
        end
        ST_MEMWAIT: begin
          if (mem_busy) begin
            wait_next = wait_cnt + CW'(1);
            if ((int'(wait_cnt) + 1) >= MEM_TIMEOUT) begin
              next_state = ST_TIMEOUT;
            end else begin
              next_state = ST_MEMWAIT;
            end
          end else begin
            next_state = ST_RUN;
            wait_next  = '0;
          end
        end
        ST_TIMEOUT: begin
          next_state = ST_TIMEOUT;
        end
        default: begin
          next_state = ST_RUN;
          wait_next  = '0;
        end
      endcase
    end
  end

  // State, wait counter, stall counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_RUN;
      wait_cnt    <= '0;
      Stall_Count <= 16'd0;
      Mem_Timeout <= 1'b0;
    end else begin
      state    <= next_state;
      wait_cnt <= wait_next;
      if (!PC_stall && (Stall_Count != 16'hFFFF)) begin
        Stall_Count <= Stall_Count + 16'd1;
      end
      if (next_state == ST_TIMEOUT) begin
        Mem_Timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MEM_TIMEOUT overridden to 4).
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ID_Rs, ID_Rt, EX_Rt;
  logic        ID_UseRs, ID_UseRt, EX_MemRd, EX_BranchTaken, ID_Jump;
  logic        Mem_Req, Mem_Ready;
  logic        PC_stall, IFID_stall, IFID_clear, IDEX_stall, IDEX_clear, EXMEM_stall;
  logic [15:0] Stall_Count;
  logic        Mem_Timeout;
  logic [5:0]  ctrl;

  int checks = 0;
  int errs   = 0;

  // ctrl = {PC_stall, IFID_stall, IFID_clear, IDEX_stall, IDEX_clear, EXMEM_stall}
  localparam logic [5:0] C_IDLE   = 6'b111111;
  localparam logic [5:0] C_LU     = 6'b001101;
  localparam logic [5:0] C_BRANCH = 6'b110101;
  localparam logic [5:0] C_JUMP   = 6'b110111;
  localparam logic [5:0] C_MEM    = 6'b001010;

  hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt),
    .EX_MemRd(EX_MemRd), .EX_Rt(EX_Rt), .EX_BranchTaken(EX_BranchTaken),
    .ID_Jump(ID_Jump), .Mem_Req(Mem_Req), .Mem_Ready(Mem_Ready),
    .PC_stall(PC_stall), .IFID_stall(IFID_stall), .IFID_clear(IFID_clear),
    .IDEX_stall(IDEX_stall), .IDEX_clear(IDEX_clear), .EXMEM_stall(EXMEM_stall),
    .Stall_Count(Stall_Count), .Mem_Timeout(Mem_Timeout)
  );

  assign ctrl = {PC_stall, IFID_stall, IFID_clear, IDEX_stall, IDEX_clear, EXMEM_stall};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    ID_Rs = 5'd0; ID_Rt = 5'd0; EX_Rt = 5'd0;
    ID_UseRs = 1'b0; ID_UseRt = 1'b0; EX_MemRd = 1'b0;
    EX_BranchTaken = 1'b0; ID_Jump = 1'b0;
    Mem_Req = 1'b0; Mem_Ready = 1'b0;
  endtask

  task automatic set_load_use_rs();
    EX_MemRd = 1'b1; EX_Rt = 5'd8; ID_Rs = 5'd8; ID_UseRs = 1'b1;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    set_idle();
    set_load_use_rs();
    Mem_Req = 1'b1;
    reset = 1'b1;
    #1;
    checks++;
    if (ctrl !== C_IDLE) begin errs++; $display("FAIL reset_ctrl got %b want %b", ctrl, C_IDLE); end
    tick(); tick();
    checks++;
    if (Stall_Count !== 16'd0) begin errs++; $display("FAIL reset_count got %0d want 0", Stall_Count); end
    checks++;
    if (Mem_Timeout !== 1'b0) begin errs++; $display("FAIL reset_timeout got %b want 0", Mem_Timeout); end
    set_idle();
    reset = 1'b0;
    #1;
    checks++;
    if (ctrl !== C_IDLE) begin errs++; $display("FAIL idle_ctrl got %b want %b", ctrl, C_IDLE); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_load_use_rs();
    #1;
    checks++;
    if (ctrl !== C_LU) begin errs++; $display("FAIL lu_rs_ctrl got %b want %b", ctrl, C_LU); end
    tick();
    set_idle();
    #1;
    checks++;
    if (Stall_Count !== 16'd1) begin errs++; $display("FAIL lu_rs_count got %0d want 1", Stall_Count); end
    checks++;
    if (ctrl !== C_IDLE) begin errs++; $display("FAIL lu_after_ctrl got %b want %b", ctrl, C_IDLE); end
    // Rt path hazard
    EX_MemRd = 1'b1; EX_Rt = 5'd17; ID_Rt = 5'd17; ID_UseRt = 1'b1; ID_Rs = 5'd3; ID_UseRs = 1'b1;
    #1;
    checks++;
    if (ctrl !== C_LU) begin errs++; $display("FAIL lu_rt_ctrl got %b want %b", ctrl, C_LU); end
    tick();
    // register matches but is not read
    set_idle();
    EX_MemRd = 1'b1; EX_Rt = 5'd8; ID_Rs = 5'd8; ID_UseRs = 1'b0; ID_Rt = 5'd8; ID_UseRt = 1'b0;
    #1;
    checks++;
    if (ctrl !== C_IDLE) begin errs++; $display("FAIL lu_unused_ctrl got %b want %b", ctrl, C_IDLE); end
    // not a load
    set_idle();
    EX_MemRd = 1'b0; EX_Rt = 5'd8; ID_Rs = 5'd8; ID_UseRs = 1'b1;
    #1;
    checks++;
    if (ctrl !== C_IDLE) begin errs++; $display("FAIL lu_noload_ctrl got %b want %b", ctrl, C_IDLE); end
    tick();
    checks++;
    if (Stall_Count !== 16'd2) begin errs++; $display("FAIL lu_count2 got %0d want 2", Stall_Count); end
    set_idle();
  endtask

  task automatic test_rt_zero();
    set_idle();
    EX_MemRd = 1'b1; EX_Rt = 5'd0; ID_Rs = 5'd0; ID_UseRs = 1'b1;
    #1;
    checks++;
    if (ctrl !== C_IDLE) begin errs++; $display("FAIL rt_zero_ctrl got %b want %b", ctrl, C_IDLE); end
    tick();
    checks++;
    if (Stall_Count !== 16'd2) begin errs++; $display("FAIL rt_zero_count got %0d want 2", Stall_Count); end
    set_idle();
  endtask

  task automatic test_branch_jump();
    set_idle();
    set_load_use_rs();
    EX_BranchTaken = 1'b1;
    ID_Jump = 1'b1;
    #1;
    checks++;
    if (ctrl !== C_BRANCH) begin errs++; $display("FAIL branch_lu_ctrl got %b want %b", ctrl, C_BRANCH); end
    tick();
    checks++;
    if (Stall_Count !== 16'd2) begin errs++; $display("FAIL branch_count got %0d want 2", Stall_Count); end
    set_idle();
    ID_Jump = 1'b1;
    #1;
    checks++;
    if (ctrl !== C_JUMP) begin errs++; $display("FAIL jump_ctrl got %b want %b", ctrl, C_JUMP); end
    set_load_use_rs();
    #1;
    checks++;
    if (ctrl !== C_LU) begin errs++; $display("FAIL jump_lu_ctrl got %b want %b", ctrl, C_LU); end
    tick();
    set_idle();
    #1;
    checks++;
    if (Stall_Count !== 16'd3) begin errs++; $display("FAIL jump_lu_count got %0d want 3", Stall_Count); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    Mem_Req = 1'b1; Mem_Ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctrl !== C_MEM) begin errs++; $display("FAIL memwait_ctrl[%0d] got %b want %b", i, ctrl, C_MEM); end
      tick();
    end
    Mem_Ready = 1'b1;
    #1;
    checks++;
    if (ctrl !== C_IDLE) begin errs++; $display("FAIL memready_ctrl got %b want %b", ctrl, C_IDLE); end
    checks++;
    if (Stall_Count !== 16'd3) begin errs++; $display("FAIL memwait_count got %0d want 3", Stall_Count); end
    tick();
    // back in RUN: a new miss starts a fresh wait without timing out early
    Mem_Ready = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (Mem_Timeout !== 1'b0) begin errs++; $display("FAIL memwait_rerun_timeout got %b want 0", Mem_Timeout); end
    // request dropped while waiting behaves as completion
    Mem_Req = 1'b0; EX_BranchTaken = 1'b1;
    #1;
    checks++;
    if (ctrl !== C_BRANCH) begin errs++; $display("FAIL memdrop_ctrl got %b want %b", ctrl, C_BRANCH); end
    tick();
    set_idle();
    #1;
    checks++;
    if (ctrl !== C_IDLE) begin errs++; $display("FAIL memdrop_idle got %b want %b", ctrl, C_IDLE); end
    checks++;
    if (Stall_Count !== 16'd6) begin errs++; $display("FAIL memdrop_count got %0d want 6", Stall_Count); end
    checks++;
    if (Mem_Timeout !== 1'b0) begin errs++; $display("FAIL memdrop_timeout got %b want 0", Mem_Timeout); end
  endtask

  task automatic test_timeout();
    do_reset();
    Mem_Req = 1'b1; Mem_Ready = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (Mem_Timeout !== 1'b0) begin errs++; $display("FAIL timeout_early got %b want 0", Mem_Timeout); end
    tick();
    checks++;
    if (Mem_Timeout !== 1'b1) begin errs++; $display("FAIL timeout_flag got %b want 1", Mem_Timeout); end
    checks++;
    if (Stall_Count !== 16'd4) begin errs++; $display("FAIL timeout_count got %0d want 4", Stall_Count); end
    Mem_Ready = 1'b1;
    #1;
    checks++;
    if (ctrl !== C_MEM) begin errs++; $display("FAIL timeout_ctrl got %b want %b", ctrl, C_MEM); end
    tick();
    checks++;
    if (Stall_Count !== 16'd5) begin errs++; $display("FAIL timeout_hold_count got %0d want 5", Stall_Count); end
    checks++;
    if (Mem_Timeout !== 1'b1) begin errs++; $display("FAIL timeout_sticky got %b want 1", Mem_Timeout); end
    reset = 1'b1;
    #1;
    checks++;
    if (ctrl !== C_IDLE) begin errs++; $display("FAIL timeout_rst_ctrl got %b want %b", ctrl, C_IDLE); end
    tick();
    reset = 1'b0;
    set_idle();
    #1;
    checks++;
    if (Mem_Timeout !== 1'b0) begin errs++; $display("FAIL timeout_rst_flag got %b want 0", Mem_Timeout); end
    checks++;
    if (Stall_Count !== 16'd0) begin errs++; $display("FAIL timeout_rst_count got %0d want 0", Stall_Count); end
    checks++;
    if (ctrl !== C_IDLE) begin errs++; $display("FAIL timeout_rst_idle got %b want %b", ctrl, C_IDLE); end
  endtask

  task automatic test_saturation();
    do_reset();
    set_load_use_rs();
    for (int i = 0; i < 65534; i++) tick();
    checks++;
    if (Stall_Count !== 16'hFFFE) begin errs++; $display("FAIL sat_pre got %h want fffe", Stall_Count); end
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (Stall_Count !== 16'hFFFF) begin errs++; $display("FAIL sat_hold got %h want ffff", Stall_Count); end
    checks++;
    if (ctrl !== C_LU) begin errs++; $display("FAIL sat_ctrl got %b want %b", ctrl, C_LU); end
    set_idle();
    tick();
    checks++;
    if (Stall_Count !== 16'hFFFF) begin errs++; $display("FAIL sat_idle got %h want ffff", Stall_Count); end
  endtask

  initial begin
    set_idle();
    reset = 1'b1;
    test_reset();
    test_load_use();
    test_rt_zero();
    test_branch_jump();
    test_mem_wait();
    test_timeout();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end

endmodule
